// File: rtl/psum_collector.sv
// South-side partial-sum collector: one FIFO lane per array column with
// independent write pointers and a shared read pointer for de-skewed rows.
module psum_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_vld,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [col-1:0]         ovf
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(depth);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [psum_bw-1:0] mem [col][depth];
    logic [AW-1:0]      wptr [col];
    logic [AW:0]        cnt [col];
    logic [AW-1:0]      rptr;
    logic [col-1:0]     wr_ok;
    logic               accept;

    always_comb begin
        o_valid = 1'b1;
        o_full  = 1'b0;
        wr_ok   = '0;
        for (int c = 0; c < col; c++) begin
            if (cnt[c] == '0)
                o_valid = 1'b0;
            if (cnt[c] == CNT_MAX)
                o_full = 1'b1;
            // fullness uses the pre-edge count, even if this edge also reads
            wr_ok[c] = wr[c] && (cnt[c] != CNT_MAX);
        end
    end

    assign o_ready = ~o_full;
    assign accept  = rd && o_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                if (wr_ok[c])
                    mem[c][wptr[c]] <= in[psum_bw*c +: psum_bw];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr  <= '0;
            out   <= '0;
            o_vld <= 1'b0;
            ovf   <= '0;
            for (int c = 0; c < col; c++) begin
                wptr[c] <= '0;
                cnt[c]  <= '0;
            end
        end else begin
            o_vld <= accept;
            if (accept) begin
                rptr <= rptr + PTR_ONE;
                for (int c = 0; c < col; c++)
                    out[psum_bw*c +: psum_bw] <= mem[c][rptr];
            end
            for (int c = 0; c < col; c++) begin
                if (wr_ok[c])
                    wptr[c] <= wptr[c] + PTR_ONE;
                if (wr[c] && !wr_ok[c])
                    ovf[c] <= 1'b1;
                if (wr_ok[c] && !accept)
                    cnt[c] <= cnt[c] + CNT_ONE;
                else if (!wr_ok[c] && accept)
                    cnt[c] <= cnt[c] - CNT_ONE;
            end
        end
    end

endmodule
